my_button_events: RTL

Button gesture decoder that consumes the debounced level produced by `my_debounce`. It turns that level into single-cycle event pulses: press, release, short click, long press, double click and, optionally, auto-repeat. It sits between the debouncer outputs and the board's control and UI logic, one instance per button. Thresholds are runtime inputs, so firmware or switches can retune them without rebuilding.

---
 rtl/my_button_pkg.sv | 27 ++
 rtl/my_button_events_if.sv | 48 ++++
 rtl/my_button_edge.sv | 21 ++
 rtl/my_button_events.sv | 123 ++++++++++++
 4 files changed

// File: rtl/my_button_pkg.sv
// my_button_events shared types: FSM state encoding and event indices.
// Event indices order the pulse vector used by downstream event muxes.
package my_button_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] PRESS1 = 3'd1;
  localparam logic [2:0] WAIT2  = 3'd2;
  localparam logic [2:0] PRESS2 = 3'd3;
  localparam logic [2:0] LONG   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = IDLE,
    S_PRESS1 = PRESS1,
    S_WAIT2  = WAIT2,
    S_PRESS2 = PRESS2,
    S_LONG   = LONG
  } state_t;

  localparam int EV_PRESS   = 0;
  localparam int EV_RELEASE = 1;
  localparam int EV_SHORT   = 2;
  localparam int EV_LONG    = 3;
  localparam int EV_DOUBLE  = 4;
  localparam int EV_REPEAT  = 5;
  localparam int EV_COUNT   = 6;

endpackage

// File: rtl/my_button_events_if.sv
// Button level, runtime thresholds and gesture event outputs.
// master drives level/thresholds; slave (the decoder) drives events.
interface my_button_events_if #(
  parameter int N = 24
);

  logic         btn_i;
  logic [N-1:0] long_value;
  logic [N-1:0] dclick_value;
  logic [N-1:0] repeat_value;

  logic press_o;
  logic release_o;
  logic short_o;
  logic long_o;
  logic double_o;
  logic repeat_o;
  logic held_o;

  modport master (
    output btn_i,
    output long_value,
    output dclick_value,
    output repeat_value,
    input  press_o,
    input  release_o,
    input  short_o,
    input  long_o,
    input  double_o,
    input  repeat_o,
    input  held_o
  );

  modport slave (
    input  btn_i,
    input  long_value,
    input  dclick_value,
    input  repeat_value,
    output press_o,
    output release_o,
    output short_o,
    output long_o,
    output double_o,
    output repeat_o,
    output held_o
  );

endinterface

// File: rtl/my_button_edge.sv
// my_edge_detect: registered copy of a level plus rise/fall strobes.
// Reusable for any single-bit level already in the clk domain.
module my_edge_detect (
  input  logic clk,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_q;

  // Loads the live level even during reset, so a level held
  // through reset release never looks like an edge.
  always_ff @(posedge clk) begin
    level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/my_button_events.sv
// my_button_events: gesture decoder (press/release/short/long/double).
// Auto-repeat in LONG is built only when BTN_REPEAT_EN is defined.
module my_button_events
  import my_button_pkg::*;
#(
  parameter int N          = 24,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input logic              sysclk,
  input logic              reset,
  my_button_events_if.slave bus
);

  logic p;
  logic rise;
  logic fall;

  state_t              state;
  logic [N-1:0]        cnt;
  logic [N-1:0]        cnt_inc;
  logic [EV_COUNT-1:0] ev_q;
  logic                held_q;

  assign p = bus.btn_i ^ ACTIVE_LOW;

  my_edge_detect u_edge (
    .clk   (sysclk),
    .level (p),
    .rise  (rise),
    .fall  (fall)
  );

  // Saturate so states without a compare can idle forever.
  assign cnt_inc = (&cnt) ? cnt : cnt + N'(1);

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ev_q   <= '0;
      held_q <= 1'b0;
    end else begin
      ev_q <= '0;
      cnt  <= cnt_inc;
      unique case (state)
        S_IDLE: begin
          if (rise) begin
            state           <= S_PRESS1;
            cnt             <= '0;
            ev_q[EV_PRESS]  <= 1'b1;
            held_q          <= 1'b1;
          end
        end
        S_PRESS1: begin
          if (fall) begin
            state            <= S_WAIT2;
            cnt              <= '0;
            ev_q[EV_RELEASE] <= 1'b1;
            held_q           <= 1'b0;
          end else if (cnt == bus.long_value) begin
            state         <= S_LONG;
            cnt           <= '0;
            ev_q[EV_LONG] <= 1'b1;
          end
        end
        S_WAIT2: begin
          if (rise) begin
            state           <= S_PRESS2;
            cnt             <= '0;
            ev_q[EV_PRESS]  <= 1'b1;
            ev_q[EV_DOUBLE] <= 1'b1;
            held_q          <= 1'b1;
          end else if (cnt == bus.dclick_value) begin
            state          <= S_IDLE;
            cnt            <= '0;
            ev_q[EV_SHORT] <= 1'b1;
          end
        end
        S_PRESS2: begin
          if (fall) begin
            state            <= S_IDLE;
            cnt              <= '0;
            ev_q[EV_RELEASE] <= 1'b1;
            held_q           <= 1'b0;
          end
        end
        S_LONG: begin
          if (fall) begin
            state            <= S_IDLE;
            cnt              <= '0;
            ev_q[EV_RELEASE] <= 1'b1;
            held_q           <= 1'b0;
          end
`ifdef BTN_REPEAT_EN
          else if (cnt == bus.repeat_value) begin
            cnt             <= '0;
            ev_q[EV_REPEAT] <= 1'b1;
          end
`endif
        end
        default: begin
          state  <= S_IDLE;
          cnt    <= '0;
          held_q <= 1'b0;
        end
      endcase
    end
  end

`ifndef BTN_REPEAT_EN
  logic unused_repeat;
  assign unused_repeat = ^bus.repeat_value;
`endif

  assign bus.press_o   = ev_q[EV_PRESS];
  assign bus.release_o = ev_q[EV_RELEASE];
  assign bus.short_o   = ev_q[EV_SHORT];
  assign bus.long_o    = ev_q[EV_LONG];
  assign bus.double_o  = ev_q[EV_DOUBLE];
  assign bus.repeat_o  = ev_q[EV_REPEAT];
  assign bus.held_o    = held_q;

endmodule
